// File: rtl/pipe_mem_arbiter_pkg.sv
// Shared definitions for the IF/MEM unified-memory arbiter: FSM encodings,
// the word returned on a bus timeout, and the default timeout depth.
package pipe_mem_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_GRANT_MEM = 3'd1,
    ST_GRANT_IF  = 3'd2,
    ST_RESP_MEM  = 3'd3,
    ST_RESP_IF   = 3'd4,
    ST_DRAIN_IF  = 3'd5
  } arb_state_e;

  localparam logic [31:0] POISON_WORD     = 32'hDEADBEEF;
  localparam int          DEFAULT_TIMEOUT = 64;

  // States in which a bus access is outstanding and the timeout runs.
  function automatic logic is_wait_state(arb_state_e s);
    return (s == ST_GRANT_MEM) || (s == ST_GRANT_IF) || (s == ST_DRAIN_IF);
  endfunction

endpackage

// File: rtl/arb_timeout_ctr.sv
// Bus-ack watchdog: counts cycles without an ack and flags terminal count
// once TIMEOUT cycles have elapsed; saturates there until cleared.
module arb_timeout_ctr #(
  parameter int TIMEOUT = 64
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;

  assign tc = (cnt == CW'(TIMEOUT));

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (enable && !tc) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/pipe_mem_arbiter.sv
// Single-port memory arbiter for the IF and MEM pipeline stages: fixed
// priority MEM > IF, one access at a time, pipeline stall while pending.
module pipe_mem_arbiter
  import pipe_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              mem_done,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_ack,
  output logic              pipe_stall,
  output logic              bus_err
);

  arb_state_e state, state_next;
  logic       grant_mem, grant_if;
  logic       wait_st, finish;
  logic       tmr_clear, tmr_en, tmr_tc;

  arb_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clock  (clock),
    .reset  (reset),
    .clear  (tmr_clear),
    .enable (tmr_en),
    .tc     (tmr_tc)
  );

  always_comb begin
    state_next = state;
    grant_mem  = 1'b0;
    grant_if   = 1'b0;
    wait_st    = is_wait_state(state);
    finish     = wait_st && (bus_ack || tmr_tc);
    tmr_en     = wait_st && !bus_ack;
    case (state)
      ST_IDLE: begin
        if (mem_req) begin
          state_next = ST_GRANT_MEM;
          grant_mem  = 1'b1;
        end else if (if_req && !if_flush) begin
          state_next = ST_GRANT_IF;
          grant_if   = 1'b1;
        end
      end
      ST_GRANT_MEM: if (finish) state_next = ST_RESP_MEM;
      ST_GRANT_IF: begin
        // A flushed fetch still finishes on the bus; only the response is dropped.
        if (finish)        state_next = if_flush ? ST_IDLE : ST_RESP_IF;
        else if (if_flush) state_next = ST_DRAIN_IF;
      end
      ST_DRAIN_IF:  if (finish) state_next = ST_IDLE;
      ST_RESP_MEM,
      ST_RESP_IF:   state_next = ST_IDLE;
      default:      state_next = ST_IDLE;
    endcase
    tmr_clear = (state_next != state) && is_wait_state(state_next);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_IDLE;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      if_rdata  <= '0;
      mem_rdata <= '0;
      bus_err   <= 1'b0;
    end else begin
      state <= state_next;
      if (grant_mem) begin
        bus_req   <= 1'b1;
        bus_we    <= mem_we;
        bus_addr  <= mem_addr;
        bus_wdata <= mem_wdata;
      end else if (grant_if) begin
        bus_req  <= 1'b1;
        bus_we   <= 1'b0;
        bus_addr <= if_addr;
      end else if (finish) begin
        bus_req <= 1'b0;
      end
      if (finish && !bus_ack) bus_err <= 1'b1;
      if (finish && state == ST_GRANT_MEM && !bus_we)
        mem_rdata <= bus_ack ? bus_rdata : DATA_W'(POISON_WORD);
      if (finish && state == ST_GRANT_IF && !if_flush)
        if_rdata <= bus_ack ? bus_rdata : DATA_W'(POISON_WORD);
    end
  end

  assign if_done    = (state == ST_RESP_IF);
  assign mem_done   = (state == ST_RESP_MEM);
  assign pipe_stall = (if_req && !if_done && !if_flush) || (mem_req && !mem_done);

endmodule

// File: tb/tb_pipe_mem_arbiter.sv
// Self-checking bench for pipe_mem_arbiter: bus memory responder with
// programmable ack latency plus a scoreboard of expected read data.
module tb_pipe_mem_arbiter;

  localparam int TMO = 8;
  localparam logic [31:0] POISON = 32'hDEADBEEF;

  logic        clock, reset;
  logic        if_req, if_flush, if_done;
  logic [31:0] if_addr, if_rdata;
  logic        mem_req, mem_we, mem_done;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        bus_req, bus_we, bus_ack;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic        pipe_stall, bus_err;

  int          pass_cnt = 0;
  int          total_cnt = 0;
  int          cyc = 0;
  logic [31:0] if_q[$];
  logic [31:0] mem_q[$];
  logic [31:0] sb_exp;
  logic [31:0] last_mem_exp;
  logic [31:0] mem_model [0:255];
  int          ack_lat = 0;
  bit          ack_en = 1'b1;
  int          wait_cnt = 0;

  pipe_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO)) dut (
    .clock      (clock),
    .reset      (reset),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_flush   (if_flush),
    .if_done    (if_done),
    .if_rdata   (if_rdata),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_done   (mem_done),
    .mem_rdata  (mem_rdata),
    .bus_req    (bus_req),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_rdata  (bus_rdata),
    .bus_ack    (bus_ack),
    .pipe_stall (pipe_stall),
    .bus_err    (bus_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [31:0] img(int w);
    if (w == 6) return 32'd31;
    return 32'hA500_0000 | (32'(w) << 2);
  endfunction

  // Memory responder: ack lands in the (ack_lat+1)-th cycle of bus_req.
  always @(negedge clock) begin
    if (bus_req) begin
      if (ack_en && wait_cnt == ack_lat) begin
        bus_ack   = 1'b1;
        bus_rdata = mem_model[bus_addr[9:2]];
        if (bus_we) mem_model[bus_addr[9:2]] = bus_wdata;
      end else begin
        bus_ack   = 1'b0;
        bus_rdata = $urandom;
      end
      wait_cnt++;
    end else begin
      bus_ack   = 1'b0;
      bus_rdata = $urandom;
      wait_cnt  = 0;
    end
  end

  // Scoreboard: every done pulse must match the oldest pending expectation.
  always @(negedge clock) begin
    if (!reset) begin
      if (mem_done) begin
        total_cnt++;
        if (mem_q.size() == 0) begin
          $display("FAIL sb_mem_unexpected: mem_done with nothing pending, mem_rdata=%h", mem_rdata);
        end else begin
          sb_exp = mem_q.pop_front();
          if (mem_rdata !== sb_exp)
            $display("FAIL sb_mem_rdata: got %h expected %h", mem_rdata, sb_exp);
          else pass_cnt++;
        end
      end
      if (if_done) begin
        total_cnt++;
        if (if_q.size() == 0) begin
          $display("FAIL sb_if_unexpected: if_done with nothing pending, if_rdata=%h", if_rdata);
        end else begin
          sb_exp = if_q.pop_front();
          if (if_rdata !== sb_exp)
            $display("FAIL sb_if_rdata: got %h expected %h", if_rdata, sb_exp);
          else pass_cnt++;
        end
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    if_req = 0; if_flush = 0; if_addr = 0;
    mem_req = 0; mem_we = 0; mem_addr = 0; mem_wdata = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    step(); step();
    total_cnt++;
    if ({bus_req, bus_we, if_done, mem_done, bus_err} !== 5'b0)
      $display("FAIL reset_ctrl: got req/we/ifd/memd/err=%b expected 00000",
               {bus_req, bus_we, if_done, mem_done, bus_err});
    else pass_cnt++;
    total_cnt++;
    if ({bus_addr, bus_wdata, if_rdata, mem_rdata} !== 128'd0)
      $display("FAIL reset_data: got addr=%h wdata=%h ifr=%h memr=%h expected all 0",
               bus_addr, bus_wdata, if_rdata, mem_rdata);
    else pass_cnt++;
    reset = 1'b0;
    step();
    total_cnt++;
    if (bus_req !== 1'b0 || pipe_stall !== 1'b0)
      $display("FAIL reset_idle: got bus_req=%b pipe_stall=%b expected 0 0", bus_req, pipe_stall);
    else pass_cnt++;
    last_mem_exp = 32'd0;
  endtask

  task automatic test_single_lw();
    ack_lat = 0; ack_en = 1'b1;
    mem_req = 1; mem_we = 0; mem_addr = 32'h18;
    mem_q.push_back(img(6));
    last_mem_exp = img(6);
    #1;
    total_cnt++;
    if (pipe_stall !== 1'b1) $display("FAIL lw_stall_c0: got %b expected 1", pipe_stall);
    else pass_cnt++;
    step();
    total_cnt++;
    if (bus_req !== 1'b1 || bus_we !== 1'b0 || bus_addr !== 32'h18 || pipe_stall !== 1'b1)
      $display("FAIL lw_bus_c1: got req=%b we=%b addr=%h stall=%b expected 1 0 00000018 1",
               bus_req, bus_we, bus_addr, pipe_stall);
    else pass_cnt++;
    step();
    total_cnt++;
    if (mem_done !== 1'b1 || mem_rdata !== 32'd31 || pipe_stall !== 1'b0)
      $display("FAIL lw_done_c2: got done=%b rdata=%h stall=%b expected 1 0000001f 0",
               mem_done, mem_rdata, pipe_stall);
    else pass_cnt++;
    mem_req = 0;
    step();
    total_cnt++;
    if (mem_done !== 1'b0 || bus_req !== 1'b0)
      $display("FAIL lw_pulse_c3: got done=%b bus_req=%b expected 0 0", mem_done, bus_req);
    else pass_cnt++;
    step();
  endtask

  task automatic test_sw_then_fetch();
    ack_lat = 0; ack_en = 1'b1;
    mem_req = 1; mem_we = 1; mem_addr = 32'h24; mem_wdata = 32'd28;
    if_req = 1; if_addr = 32'h28;
    mem_q.push_back(last_mem_exp);
    if_q.push_back(img(10));
    step();
    total_cnt++;
    if (bus_req !== 1'b1 || bus_we !== 1'b1 || bus_addr !== 32'h24 || bus_wdata !== 32'd28)
      $display("FAIL sw_bus_c1: got req=%b we=%b addr=%h wdata=%h expected 1 1 00000024 0000001c",
               bus_req, bus_we, bus_addr, bus_wdata);
    else pass_cnt++;
    step();
    total_cnt++;
    if (mem_done !== 1'b1 || if_done !== 1'b0 || pipe_stall !== 1'b1)
      $display("FAIL sw_done_c2: got memd=%b ifd=%b stall=%b expected 1 0 1", mem_done, if_done, pipe_stall);
    else pass_cnt++;
    mem_req = 0; mem_we = 0;
    step();
    total_cnt++;
    if (bus_req !== 1'b0 || pipe_stall !== 1'b1)
      $display("FAIL sw_gap_c3: got bus_req=%b stall=%b expected 0 1", bus_req, pipe_stall);
    else pass_cnt++;
    step();
    total_cnt++;
    if (bus_req !== 1'b1 || bus_we !== 1'b0 || bus_addr !== 32'h28)
      $display("FAIL if_bus_c4: got req=%b we=%b addr=%h expected 1 0 00000028", bus_req, bus_we, bus_addr);
    else pass_cnt++;
    step();
    total_cnt++;
    if (if_done !== 1'b1 || if_rdata !== img(10))
      $display("FAIL if_done_c5: got done=%b rdata=%h expected 1 %h", if_done, if_rdata, img(10));
    else pass_cnt++;
    if_req = 0;
    step(); step();
  endtask

  task automatic test_flush();
    int start;
    int n;
    ack_lat = 2; ack_en = 1'b1;
    if_req = 1; if_addr = 32'h40;
    step();
    total_cnt++;
    if (bus_req !== 1'b1 || bus_addr !== 32'h40)
      $display("FAIL fl_bus_c1: got req=%b addr=%h expected 1 00000040", bus_req, bus_addr);
    else pass_cnt++;
    step();
    if_flush = 1;
    #1;
    total_cnt++;
    if (pipe_stall !== 1'b0) $display("FAIL fl_stall_c2: got %b expected 0", pipe_stall);
    else pass_cnt++;
    step();
    if_flush = 0; if_req = 0;
    total_cnt++;
    if (bus_req !== 1'b1) $display("FAIL fl_drain_c3: got bus_req=%b expected 1", bus_req);
    else pass_cnt++;
    step();
    total_cnt++;
    if (if_done !== 1'b0 || bus_req !== 1'b0 || if_rdata !== img(10))
      $display("FAIL fl_after_c4: got done=%b req=%b rdata=%h expected 0 0 %h",
               if_done, bus_req, if_rdata, img(10));
    else pass_cnt++;
    if_req = 1; if_addr = 32'h44;
    if_q.push_back(img(17));
    start = cyc;
    n = 0;
    step();
    while (!if_done && n < 20) begin step(); n++; end
    total_cnt++;
    if (!if_done || cyc - start != 4)
      $display("FAIL fl_refetch: got done=%b after %0d cycles expected 1 after 4", if_done, cyc - start);
    else pass_cnt++;
    if_req = 0;
    step(); step();
  endtask

  task automatic test_timeout();
    int start;
    int n;
    ack_en = 1'b0;
    mem_req = 1; mem_we = 0; mem_addr = 32'h50;
    mem_q.push_back(POISON);
    last_mem_exp = POISON;
    start = cyc;
    step();
    total_cnt++;
    if (bus_req !== 1'b1 || bus_err !== 1'b0)
      $display("FAIL to_start: got req=%b err=%b expected 1 0", bus_req, bus_err);
    else pass_cnt++;
    n = 0;
    while (!mem_done && n < 20) begin step(); n++; end
    total_cnt++;
    if (!mem_done || cyc - start != 10)
      $display("FAIL to_latency: got done=%b at cycle %0d expected 1 at 10", mem_done, cyc - start);
    else pass_cnt++;
    total_cnt++;
    if (mem_rdata !== POISON || bus_err !== 1'b1 || bus_req !== 1'b0)
      $display("FAIL to_result: got rdata=%h err=%b req=%b expected deadbeef 1 0",
               mem_rdata, bus_err, bus_req);
    else pass_cnt++;
    mem_req = 0;
    ack_en = 1'b1;
    step(); step(); step();
    total_cnt++;
    if (bus_err !== 1'b1) $display("FAIL to_sticky: got bus_err=%b expected 1", bus_err);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int start;
    int n;
    ack_lat = 2; ack_en = 1'b1;
    if_req = 1; if_addr = 32'h60;
    step();
    total_cnt++;
    if (bus_req !== 1'b1) $display("FAIL rm_grant: got bus_req=%b expected 1", bus_req);
    else pass_cnt++;
    reset = 1'b1;
    step();
    total_cnt++;
    if (bus_req !== 1'b0 || if_done !== 1'b0 || bus_err !== 1'b0 || mem_rdata !== 32'd0)
      $display("FAIL rm_cleared: got req=%b ifd=%b err=%b memr=%h expected 0 0 0 0",
               bus_req, if_done, bus_err, mem_rdata);
    else pass_cnt++;
    reset = 1'b0; if_req = 0;
    last_mem_exp = 32'd0;
    step();
    if_req = 1; if_addr = 32'h64;
    if_q.push_back(img(25));
    start = cyc;
    n = 0;
    step();
    while (!if_done && n < 20) begin step(); n++; end
    total_cnt++;
    if (!if_done || cyc - start != 4 || if_rdata !== img(25))
      $display("FAIL rm_refetch: got done=%b after %0d rdata=%h expected 1 after 4 %h",
               if_done, cyc - start, if_rdata, img(25));
    else pass_cnt++;
    if_req = 0;
    step(); step();
  endtask

  task automatic test_back_to_back();
    int pcs[3];
    int d[3];
    int start;
    int n;
    pcs[0] = 16; pcs[1] = 20; pcs[2] = 24;
    ack_lat = 1; ack_en = 1'b1;
    if_req = 1; if_addr = 32'(pcs[0]);
    if_q.push_back(img(pcs[0] / 4));
    start = cyc;
    for (int i = 0; i < 3; i++) begin
      n = 0;
      step();
      while (!if_done && n < 12) begin step(); n++; end
      d[i] = cyc;
      total_cnt++;
      if (!if_done || if_rdata !== img(pcs[i] / 4))
        $display("FAIL b2b_fetch%0d: got done=%b rdata=%h expected 1 %h",
                 i, if_done, if_rdata, img(pcs[i] / 4));
      else pass_cnt++;
      if (i < 2) begin
        if_addr = 32'(pcs[i+1]);
        if_q.push_back(img(pcs[i+1] / 4));
      end else begin
        if_req = 0;
      end
    end
    total_cnt++;
    if (d[0] - start != 3 || d[1] - d[0] != 4 || d[2] - d[1] != 4)
      $display("FAIL b2b_spacing: got first=%0d gaps=%0d,%0d expected 3 4,4",
               d[0] - start, d[1] - d[0], d[2] - d[1]);
    else pass_cnt++;
    step(); step();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem_model[i] = img(i);
    bus_ack = 1'b0;
    bus_rdata = 32'd0;
    test_reset();
    test_single_lw();
    test_sw_then_fetch();
    test_flush();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    total_cnt++;
    if (if_q.size() != 0 || mem_q.size() != 0)
      $display("FAIL sb_drain: got pending if=%0d mem=%0d expected 0 0", if_q.size(), mem_q.size());
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation exceeded time limit, %0d/%0d passed", pass_cnt, total_cnt);
    $fatal(1);
  end

endmodule
